// File: rtl/tone_sequencer_if.sv
// Song ROM bus between the sequencer (master) and an external ROM (slave).
// The ROM returns {note[7:4], dur[3:0]} in the same cycle as the address.
interface tone_sequencer_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: note selection, square-wave tone generation, ROM-driven
// autoplay and interactive lesson sequencing for an N_KEYS keyboard.
module tone_sequencer #(
    parameter int unsigned             N_KEYS       = 8,
    parameter int unsigned             DIV_W        = 18,
    parameter logic [N_KEYS*DIV_W-1:0] HALF_PERIODS = {
        18'd95602,  18'd101215, 18'd113636, 18'd127551,
        18'd143266, 18'd151685, 18'd170262, 18'd191110},
    parameter int unsigned             BEAT_DIV     = 25_000_000,
    parameter int unsigned             ADDR_W       = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        mode_sel,
    input  logic              mode_load,
    input  logic [N_KEYS-1:0] keys,
    tone_sequencer_if.master  rom_bus,
    output logic              tone,
    output logic [3:0]        note,
    output logic [3:0]        expect_note,
    output logic [N_KEYS-1:0] led,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count
);

    localparam int unsigned BEAT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_FREE   = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_LESSON = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        A_FETCH,
        A_PLAY,
        A_DONE
    } auto_state_t;

    typedef enum logic [1:0] {
        L_FETCH,
        L_WAIT,
        L_RELEASE,
        L_DONE
    } les_state_t;

    // state and datapath registers
    mode_t              r_mode;
    auto_state_t        r_auto_st;
    les_state_t         r_les_st;
    logic [3:0]         r_note;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [3:0]         r_remain;
    logic [3:0]         r_expect;
    logic [7:0]         r_err;
    logic               r_correct;
    logic [BEAT_W-1:0]  r_beat;
    logic [DIV_W-1:0]   r_div;
    logic               r_tone;

    // next-state values
    mode_t              w_mode_nxt;
    auto_state_t        w_auto_nxt;
    les_state_t         w_les_nxt;
    logic [3:0]         w_note_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [3:0]         w_remain_nxt;
    logic [3:0]         w_expect_nxt;
    logic [7:0]         w_err_nxt;
    logic               w_correct_nxt;

    // decoded helpers
    logic               w_tick;
    logic [3:0]         w_code;
    logic [3:0]         w_dur;
    logic [3:0]         w_lowest;
    logic [N_KEYS-1:0]  w_note_mask;
    logic [N_KEYS-1:0]  w_expect_mask;
    logic [DIV_W-1:0]   w_half;
    logic               w_key_ok;

    assign w_code   = rom_bus.rom_data[7:4];
    assign w_dur    = rom_bus.rom_data[3:0];
    assign w_tick   = (r_beat == BEAT_W'(BEAT_DIV - 1));
    assign w_key_ok = (keys == w_expect_mask) && (w_expect_mask != '0);

    assign rom_bus.rom_addr = r_rom_addr;
    assign tone             = r_tone;
    assign note             = r_note;
    assign err_count        = r_err;

    // Per-key decode: one-hot masks for note/expect, half-period lookup and
    // lowest pressed key. Codes above N_KEYS have no table entry and stay silent.
    always_comb begin
        w_note_mask   = '0;
        w_expect_mask = '0;
        w_half        = '0;
        w_lowest      = '0;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            w_note_mask[k]   = (r_note == 4'(k + 1));
            w_expect_mask[k] = (r_expect == 4'(k + 1));
            if (r_note == 4'(k + 1)) begin
                w_half = HALF_PERIODS[k*DIV_W +: DIV_W];
            end
            if (keys[k] && (w_lowest == '0)) begin
                w_lowest = 4'(k + 1);
            end
        end
    end

    // Free-running beat counter; only RESET clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_beat <= '0;
        end else if (w_tick) begin
            r_beat <= '0;
        end else begin
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    // Square-wave divider; restarts low whenever the note changes or is silent.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_div  <= '0;
            r_tone <= 1'b0;
        end else if (mode_load || (w_note_nxt != r_note) || (r_note == '0) || (w_half == '0)) begin
            r_div  <= '0;
            r_tone <= 1'b0;
        end else if (r_div == w_half - DIV_W'(1)) begin
            r_div  <= '0;
            r_tone <= ~r_tone;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    // Mode register update on mode_load; selector value 3 aliases FREE.
    always_comb begin
        w_mode_nxt = r_mode;
        if (mode_load) begin
            case (mode_sel)
                2'd1:    w_mode_nxt = MODE_AUTO;
                2'd2:    w_mode_nxt = MODE_LESSON;
                default: w_mode_nxt = MODE_FREE;
            endcase
        end
    end

    // State register for mode, both sequencer FSMs and their datapath.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mode     <= MODE_FREE;
            r_auto_st  <= A_FETCH;
            r_les_st   <= L_FETCH;
            r_note     <= '0;
            r_rom_addr <= '0;
            r_remain   <= '0;
            r_expect   <= '0;
            r_err      <= '0;
            r_correct  <= 1'b0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_auto_st  <= w_auto_nxt;
            r_les_st   <= w_les_nxt;
            r_note     <= w_note_nxt;
            r_rom_addr <= w_addr_nxt;
            r_remain   <= w_remain_nxt;
            r_expect   <= w_expect_nxt;
            r_err      <= w_err_nxt;
            r_correct  <= w_correct_nxt;
        end
    end

    // Next-state logic; mode_load takes priority over every FSM event.
    always_comb begin
        w_auto_nxt    = r_auto_st;
        w_les_nxt     = r_les_st;
        w_note_nxt    = r_note;
        w_addr_nxt    = r_rom_addr;
        w_remain_nxt  = r_remain;
        w_expect_nxt  = r_expect;
        w_err_nxt     = r_err;
        w_correct_nxt = r_correct;
        if (mode_load) begin
            w_auto_nxt    = A_FETCH;
            w_les_nxt     = L_FETCH;
            w_note_nxt    = '0;
            w_addr_nxt    = '0;
            w_expect_nxt  = '0;
            w_err_nxt     = '0;
            w_correct_nxt = 1'b0;
        end else begin
            case (r_mode)
                MODE_AUTO: begin
                    case (r_auto_st)
                        A_FETCH: begin
                            if (w_code == 4'hF) begin
                                w_note_nxt = '0;
                                w_auto_nxt = A_DONE;
                            end else begin
                                w_note_nxt   = w_code;
                                w_remain_nxt = (w_dur == '0) ? 4'd1 : w_dur;
                                w_auto_nxt   = A_PLAY;
                            end
                        end
                        A_PLAY: begin
                            if (w_tick) begin
                                if (r_remain <= 4'd1) begin
                                    w_addr_nxt = r_rom_addr + ADDR_W'(1);
                                    w_auto_nxt = A_FETCH;
                                end else begin
                                    w_remain_nxt = r_remain - 4'd1;
                                end
                            end
                        end
                        A_DONE:  w_note_nxt = '0;
                        default: w_auto_nxt = A_FETCH;
                    endcase
                end
                MODE_LESSON: begin
                    case (r_les_st)
                        L_FETCH: begin
                            if (w_code == 4'h0) begin
                                w_addr_nxt = r_rom_addr + ADDR_W'(1);
                            end else if (w_code == 4'hF) begin
                                w_note_nxt = '0;
                                w_les_nxt  = L_DONE;
                            end else begin
                                w_expect_nxt = w_code;
                                w_les_nxt    = L_WAIT;
                            end
                        end
                        L_WAIT: begin
                            if (keys != '0) begin
                                w_les_nxt = L_RELEASE;
                                if (w_key_ok) begin
                                    w_note_nxt    = r_expect;
                                    w_correct_nxt = 1'b1;
                                end else begin
                                    w_note_nxt    = w_lowest;
                                    w_correct_nxt = 1'b0;
                                    if (r_err != 8'hFF) begin
                                        w_err_nxt = r_err + 8'd1;
                                    end
                                end
                            end
                        end
                        L_RELEASE: begin
                            if (keys == '0) begin
                                w_note_nxt = '0;
                                if (r_correct) begin
                                    w_addr_nxt = r_rom_addr + ADDR_W'(1);
                                    w_les_nxt  = L_FETCH;
                                end else begin
                                    w_les_nxt  = L_WAIT;
                                end
                            end
                        end
                        default: w_note_nxt = '0;
                    endcase
                end
                default: w_note_nxt = w_lowest;
            endcase
        end
    end

    // Output decode of mode and FSM state.
    always_comb begin
        led         = '0;
        busy        = 1'b0;
        done        = 1'b0;
        expect_note = '0;
        case (r_mode)
            MODE_AUTO: begin
                busy = (r_auto_st != A_DONE);
                done = (r_auto_st == A_DONE);
                led  = w_note_mask;
            end
            MODE_LESSON: begin
                busy = (r_les_st != L_DONE);
                done = (r_les_st == L_DONE);
                if (r_les_st != L_DONE) begin
                    expect_note = r_expect;
                    led         = w_expect_mask;
                end
            end
            default: led = keys;
        endcase
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: FREE vector table plus hand-written
// AUTO, LESSON, address-wrap and asynchronous-reset sequences.
module tb_tone_sequencer;

    localparam logic [8*18-1:0] HP = {18'd2, 18'd9, 18'd8, 18'd7,
                                      18'd6, 18'd4, 18'd3, 18'd5};

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;

    logic [1:0] mode_sel = 2'd0;
    logic       mode_load = 1'b0;
    logic [7:0] keys = '0;
    logic       tone, busy, done;
    logic [3:0] note, expect_note;
    logic [7:0] led, err_count;

    logic [1:0] mode_sel2 = 2'd0;
    logic       mode_load2 = 1'b0;
    logic [7:0] keys2 = '0;
    logic       tone2, busy2, done2;
    logic [3:0] note2, expect_note2;
    logic [7:0] led2, err_count2;

    logic [7:0] rom6 [64];

    int n_vec = 0;
    int n_err = 0;

    tone_sequencer_if #(.ADDR_W(6)) bus6 ();
    tone_sequencer_if #(.ADDR_W(2)) bus2 ();

    assign bus6.rom_data = rom6[bus6.rom_addr];
    assign bus2.rom_data = 8'h11;

    tone_sequencer #(
        .N_KEYS(8), .DIV_W(18), .HALF_PERIODS(HP), .BEAT_DIV(10), .ADDR_W(6)
    ) dut (
        .CLK(CLK), .RESET(RESET), .mode_sel(mode_sel), .mode_load(mode_load),
        .keys(keys), .rom_bus(bus6), .tone(tone), .note(note),
        .expect_note(expect_note), .led(led), .busy(busy), .done(done),
        .err_count(err_count)
    );

    tone_sequencer #(
        .N_KEYS(8), .DIV_W(18), .HALF_PERIODS(HP), .BEAT_DIV(10), .ADDR_W(2)
    ) dut2 (
        .CLK(CLK), .RESET(RESET), .mode_sel(mode_sel2), .mode_load(mode_load2),
        .keys(keys2), .rom_bus(bus2), .tone(tone2), .note(note2),
        .expect_note(expect_note2), .led(led2), .busy(busy2), .done(done2),
        .err_count(err_count2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] keys;
        logic [3:0] note;
        logic [7:0] led;
    } fvec_t;

    fvec_t fv [9];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int which, input logic [1:0] m);
        if (which == 0) begin
            mode_sel  = m;
            mode_load = 1'b1;
        end else begin
            mode_sel2  = m;
            mode_load2 = 1'b1;
        end
        step();
        mode_load  = 1'b0;
        mode_load2 = 1'b0;
    endtask

    initial begin
        int seg_val [8];
        int seg_len [8];
        int nseg, cur, len, cyc, bad, wrapped, prev, seen_hi;

        fv[0] = '{8'h00, 4'd0, 8'h00};
        fv[1] = '{8'h01, 4'd1, 8'h01};
        fv[2] = '{8'h02, 4'd2, 8'h02};
        fv[3] = '{8'h03, 4'd1, 8'h03};
        fv[4] = '{8'h80, 4'd8, 8'h80};
        fv[5] = '{8'hC0, 4'd7, 8'hC0};
        fv[6] = '{8'h10, 4'd5, 8'h10};
        fv[7] = '{8'hFF, 4'd1, 8'hFF};
        fv[8] = '{8'h24, 4'd3, 8'h24};

        for (int i = 0; i < 64; i++) rom6[i] = 8'hF0;
        rom6[0] = 8'h12;
        rom6[1] = 8'h03;
        rom6[2] = 8'h21;
        rom6[3] = 8'hF0;

        // reset state
        step();
        step();
        chk("rst_tone", tone, 0);
        chk("rst_note", note, 0);
        chk("rst_expect", expect_note, 0);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_count, 0);
        chk("rst_addr", bus6.rom_addr, 0);
        RESET = 1'b0;
        step();

        // FREE table
        for (int i = 0; i < 9; i++) begin
            keys = fv[i].keys;
            step();
            chk($sformatf("free_note[%0d]", i), note, fv[i].note);
            chk($sformatf("free_led[%0d]", i), led, fv[i].led);
        end
        chk("free_busy", busy, 0);
        chk("free_expect", expect_note, 0);

        // FREE tone: one-cycle note latency, period 10 for half-period 5
        keys = '0;
        step();
        step();
        keys = 8'h03;
        chk("free_latency_before", note, 0);
        step();
        chk("free_latency_after", note, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tone !== 1'((i / 5) % 2)) bad++;
            step();
        end
        chk("free_tone_pattern_errs", bad, 0);
        keys = '0;
        step();
        chk("free_release_note", note, 0);
        chk("free_release_tone", tone, 0);

        // AUTO: note 1 x2 ticks, rest x3, note 2 x1, end
        load(0, 2'd1);
        chk("auto_fetch_note", note, 0);
        chk("auto_busy_fetch", busy, 1);
        step();
        chk("auto_first_note", note, 1);
        chk("auto_led", led, 8'h01);
        for (int i = 0; i < 8; i++) begin
            seg_val[i] = -1;
            seg_len[i] = -1;
        end
        cur = 1; len = 1; nseg = 0; cyc = 0;
        while (!done && cyc < 300) begin
            step();
            cyc++;
            if (int'(note) == cur) begin
                len++;
            end else begin
                if (nseg < 8) begin
                    seg_val[nseg] = cur;
                    seg_len[nseg] = len;
                end
                nseg++;
                cur = note;
                len = 1;
            end
        end
        chk("auto_done_in_time", int'(cyc < 300), 1);
        chk("auto_nseg", nseg, 3);
        chk("auto_seg0_val", seg_val[0], 1);
        chk("auto_seg0_len_12to21", int'(seg_len[0] >= 12 && seg_len[0] <= 21), 1);
        chk("auto_seg1_val", seg_val[1], 0);
        chk("auto_seg1_len", seg_len[1], 30);
        chk("auto_seg2_val", seg_val[2], 2);
        chk("auto_seg2_len", seg_len[2], 10);
        chk("auto_done", done, 1);
        chk("auto_busy_end", busy, 0);
        chk("auto_addr_end", bus6.rom_addr, 3);
        chk("auto_note_end", note, 0);
        chk("auto_tone_end", tone, 0);

        // LESSON walk-through
        load(0, 2'd2);
        chk("les_done_cleared", done, 0);
        step();
        chk("les_expect1", expect_note, 1);
        chk("les_led1", led, 8'h01);
        chk("les_busy", busy, 1);
        keys = 8'h02;
        step();
        step();
        step();
        chk("les_wrong_err_once", err_count, 1);
        chk("les_wrong_note", note, 2);
        keys = '0;
        step();
        chk("les_wrong_rel_note", note, 0);
        chk("les_wrong_addr", bus6.rom_addr, 0);
        chk("les_wrong_expect", expect_note, 1);
        keys = 8'h01;
        step();
        chk("les_right_note", note, 1);
        keys = '0;
        step();
        step();
        step();
        chk("les_expect2", expect_note, 2);
        chk("les_addr2", bus6.rom_addr, 2);
        chk("les_led2", led, 8'h02);
        keys = 8'h02;
        step();
        chk("les_right2_note", note, 2);
        keys = '0;
        step();
        step();
        chk("les_done", done, 1);
        chk("les_busy_end", busy, 0);
        chk("les_expect_end", expect_note, 0);
        chk("les_err_end", err_count, 1);
        chk("les_addr_end", bus6.rom_addr, 3);

        // LESSON: chord counts as wrong, then saturation
        load(0, 2'd2);
        chk("sat_err_cleared", err_count, 0);
        step();
        keys = 8'h03;
        step();
        chk("chord_err", err_count, 1);
        chk("chord_note", note, 1);
        keys = '0;
        step();
        chk("chord_no_advance", bus6.rom_addr, 0);
        chk("chord_expect", expect_note, 1);
        for (int i = 0; i < 256; i++) begin
            keys = 8'h02;
            step();
            keys = '0;
            step();
        end
        chk("sat_err", err_count, 255);

        // AUTO address wrap with ROM 0x11 everywhere (ADDR_W=2)
        load(1, 2'd1);
        step();
        chk("wrap_first_note", note2, 1);
        bad = 0; wrapped = 0; prev = bus2.rom_addr;
        for (int i = 0; i < 100; i++) begin
            step();
            if (note2 != 4'd1) bad++;
            if (prev == 3 && bus2.rom_addr == 2'd0) wrapped = 1;
            prev = bus2.rom_addr;
        end
        chk("wrap_note_errs", bad, 0);
        chk("wrap_seen", wrapped, 1);
        chk("wrap_busy", busy2, 1);
        chk("wrap_done", done2, 0);

        // asynchronous RESET while tone is high
        seen_hi = 0;
        for (int i = 0; i < 40 && seen_hi == 0; i++) begin
            if (tone2) seen_hi = 1;
            else step();
        end
        chk("rst_mid_tone_high", seen_hi, 1);
        #2 RESET = 1'b1;
        #1;
        chk("rstm_tone", tone2, 0);
        chk("rstm_note", note2, 0);
        chk("rstm_busy", busy2, 0);
        chk("rstm_done", done2, 0);
        chk("rstm_addr", bus2.rom_addr, 0);
        chk("rstm_led", led2, 0);
        chk("rstm_expect", expect_note2, 0);
        step();
        RESET = 1'b0;
        keys2 = 8'h04;
        step();
        chk("rstm_free_note", note2, 3);
        chk("rstm_free_led", led2, 8'h04);
        chk("rstm_free_busy", busy2, 0);

        // mode_sel=3 behaves as FREE
        load(1, 2'd3);
        keys2 = 8'h08;
        step();
        chk("mode3_note", note2, 4);
        chk("mode3_led", led2, 8'h08);
        chk("mode3_busy", busy2, 0);
        chk("mode3_expect", expect_note2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
